// File: rtl/fase_pkg.sv
// Shared types and constants for the fetch stage: FSM state, next-PC select and reset NOP.
package fase_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StBubble,
        StTrap
    } fetch_state_t;

    typedef enum logic [1:0] {
        SelSeq,
        SelJump,
        SelBranch,
        SelHold
    } next_pc_sel_t;

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: redirect/stall controls, ROM port and registered instruction outputs.
interface fetch_pc_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              stall;
    logic              jump;
    logic [XLEN-1:0]   jump_target;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_target;
    logic [ADDR_W-1:0] rom_addr;
    logic [XLEN-1:0]   rom_data;
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   instr_pc;
    logic [XLEN-1:0]   instr_pc4;
    logic              instr_valid;
    logic              trap;

    modport master (
        input  stall, jump, jump_target, branch_taken, branch_target, rom_data,
        output rom_addr, instr, instr_pc, instr_pc4, instr_valid, trap
    );

    modport slave (
        output stall, jump, jump_target, branch_taken, branch_target, rom_data,
        input  rom_addr, instr, instr_pc, instr_pc4, instr_valid, trap
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select (sequential / jump / branch / hold) and misalignment flag.
// FETCH_MISALIGN_TRAP_EN: keep target[1:0] and flag misalignment instead of masking it.
module fetch_next_pc
    import fase_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] fetch_pc_i,
    input  logic            stall_i,
    input  logic            instr_valid_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output next_pc_sel_t    sel_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] target;

    always_comb begin
        target     = jump_i ? jump_target_i : branch_target_i;
        misalign_o = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_o = |target[1:0];
`else
        target[1:0] = 2'b00;
`endif
        // Redirects only count once there is a real instruction to redirect from.
        if ((jump_i || branch_taken_i) && instr_valid_i) begin
            sel_o     = jump_i ? SelJump : SelBranch;
            next_pc_o = target;
        end else if (stall_i) begin
            sel_o     = SelHold;
            next_pc_o = fetch_pc_i;
        end else begin
            sel_o     = SelSeq;
            next_pc_o = fetch_pc_i + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// Instruction-fetch stage: owns the PC, addresses the ROM and registers the fetched word.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets enter a sticky TRAP state.
module fetch_pc
    import fase_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic        clk,
    input logic        reset,
    fetch_pc_if.master bus
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            trap_q, trap_d;

    logic [XLEN-1:0] next_pc;
    next_pc_sel_t    sel;
    logic            misalign;

    fetch_next_pc #(
        .XLEN(XLEN)
    ) u_next_pc (
        .fetch_pc_i     (fetch_pc_q),
        .stall_i        (bus.stall),
        .instr_valid_i  (instr_valid_q),
        .jump_i         (bus.jump),
        .jump_target_i  (bus.jump_target),
        .branch_taken_i (bus.branch_taken),
        .branch_target_i(bus.branch_target),
        .next_pc_o      (next_pc),
        .sel_o          (sel),
        .misalign_o     (misalign)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        trap_d        = trap_q;
        unique case (state_q)
            // BOOT presents RESET_PC to the ROM for one cycle before the first capture.
            StBoot: begin
                if (!bus.stall) state_d = StRun;
            end
            StRun, StBubble: begin
                unique case (sel)
                    SelJump, SelBranch: begin
                        fetch_pc_d    = next_pc;
                        instr_valid_d = 1'b0;
                        state_d       = StBubble;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (misalign) begin
                            state_d = StTrap;
                            trap_d  = 1'b1;
                        end
`endif
                    end
                    SelSeq: begin
                        instr_d       = bus.rom_data;
                        instr_pc_d    = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        fetch_pc_d    = next_pc;
                        state_d       = StRun;
                    end
                    default: ;
                endcase
            end
            StTrap: ;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StBoot;
            fetch_pc_q    <= XLEN'(RESET_PC);
            instr_q       <= XLEN'(NOP_INSTR);
            instr_pc_q    <= XLEN'(RESET_PC);
            instr_valid_q <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            trap_q        <= trap_d;
        end
    end

    assign bus.rom_addr    = fetch_pc_q[ADDR_W+1:2];
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_pc4   = instr_pc_q + XLEN'(4);
    assign bus.instr_valid = instr_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.trap        = trap_q;
`else
    assign bus.trap        = 1'b0;
    logic unused_misalign;
    assign unused_misalign = misalign ^ trap_q;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc; ROM word n holds value n.
module tb_fetch_pc;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_pc_if #(.XLEN(32), .ADDR_W(8)) bus ();

    fetch_pc #(
        .XLEN    (32),
        .ADDR_W  (8),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.rom_data = 32'(bus.rom_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.stall         = 1'b0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'h0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
    endtask

    task automatic check_instr(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check_eq({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check_eq({tag, "_pc"}, bus.instr_pc, pc);
        check_eq({tag, "_instr"}, bus.instr, ins);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_instr"}, bus.instr, 32'h0000_0013);
        check_eq({tag, "_pc"}, bus.instr_pc, 32'h0);
        check_eq({tag, "_pc4"}, bus.instr_pc4, 32'h4);
        check_eq({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check_eq({tag, "_trap"}, 32'(bus.trap), 32'd0);
        check_eq({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'h0);
    endtask

    initial begin
        clear_ctl();
        reset = 1'b1;
        step();
        step();
        check_reset("rst");

        // Boot cycle, then sequential fetch.
        reset = 1'b0;
        step();
        check_eq("boot_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("boot_rom_addr", 32'(bus.rom_addr), 32'h0);
        step();
        check_instr("seq0", 32'h0, 32'h0);
        check_eq("seq0_pc4", bus.instr_pc4, 32'h4);
        step();
        check_instr("seq1", 32'h4, 32'h1);
        step();
        check_instr("seq2", 32'h8, 32'h2);

        // Stall freezes everything for three cycles.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_instr("stall", 32'h8, 32'h2);
            check_eq("stall_rom_addr", 32'(bus.rom_addr), 32'h3);
        end
        bus.stall = 1'b0;
        step();
        check_instr("resume", 32'hC, 32'h3);
        step();
        check_instr("seq4", 32'h10, 32'h4);

        // Taken branch: one bubble, then target.
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        step();
        clear_ctl();
        check_eq("br_bubble_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("br_rom_addr", 32'(bus.rom_addr), 32'h10);
        step();
        check_instr("br_tgt", 32'h40, 32'h10);

        // Jump beats branch, and redirect beats stall.
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h80;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        bus.stall         = 1'b1;
        step();
        clear_ctl();
        check_eq("jmp_bubble_valid", 32'(bus.instr_valid), 32'd0);
        step();
        check_instr("jmp_tgt", 32'h80, 32'h20);

        // Redirect held into the bubble is ignored.
        bus.jump        = 1'b1;
        bus.jump_target = 32'h100;
        step();
        check_eq("j2_bubble_valid", 32'(bus.instr_valid), 32'd0);
        bus.jump_target = 32'h200;
        step();
        clear_ctl();
        check_instr("j2_ignore", 32'h100, 32'h40);

        // PC wrap at the top of the address space.
        bus.jump        = 1'b1;
        bus.jump_target = 32'hFFFF_FFFC;
        step();
        clear_ctl();
        check_eq("wrap_rom_addr0", 32'(bus.rom_addr), 32'hFF);
        step();
        check_instr("wrap_top", 32'hFFFF_FFFC, 32'hFF);
        check_eq("wrap_pc4", bus.instr_pc4, 32'h0);
        check_eq("wrap_rom_addr1", 32'(bus.rom_addr), 32'h0);
        step();
        check_instr("wrap_zero", 32'h0, 32'h0);

        // Misaligned redirect target.
        bus.jump        = 1'b1;
        bus.jump_target = 32'h42;
        step();
        clear_ctl();
        check_eq("mis_valid", 32'(bus.instr_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("mis_trap", 32'(bus.trap), 32'd1);
        bus.stall = 1'b1;
        step();
        check_eq("trap_hold_stall", 32'(bus.trap), 32'd1);
        bus.stall       = 1'b0;
        bus.jump        = 1'b1;
        bus.jump_target = 32'h80;
        step();
        clear_ctl();
        check_eq("trap_hold_jump", 32'(bus.trap), 32'd1);
        check_eq("trap_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("trap_rom_addr", 32'(bus.rom_addr), 32'h10);
`else
        check_eq("mis_trap", 32'(bus.trap), 32'd0);
        step();
        check_instr("mis_masked", 32'h40, 32'h10);
`endif

        // Mid-run reset wins over stall and redirect.
        reset             = 1'b1;
        bus.stall         = 1'b1;
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h80;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        step();
        check_reset("rst2");
        reset = 1'b0;
        clear_ctl();
        step();
        check_eq("rst2_boot_valid", 32'(bus.instr_valid), 32'd0);
        step();
        check_instr("rst2_seq0", 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
